true_dual_port_ram_v2: RTL and testbench

Parametrised successor to the 8x64 true dual-port RAM. It has two independent read/write ports on one clock, each with a port enable and per-byte write enables. Read-during-write behaviour is selectable, an output register stage is optional, and same-address collisions between the ports are detected and resolved deterministically. It is the generic on-chip buffer for the datapath blocks that follow.

---
 rtl/true_dual_port_ram_v2_pkg.sv | 37 +++
 rtl/true_dual_port_ram_v2_out_pipe.sv | 81 ++++++++
 rtl/true_dual_port_ram_v2.sv | 138 +++++++++++++
 tb/tb_true_dual_port_ram_v2.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/true_dual_port_ram_v2_pkg.sv
// ram_pkg: shared constants and helpers for the true dual-port RAM family.
//   RDW_WRITE_FIRST / RDW_READ_FIRST : same-port read-during-write selectors
//   num_lanes()   : number of byte-enable lanes in a word
//   merge_bytes() : per-lane merge of a new word into an old word
// merge_bytes works on a fixed maximum width so one function serves every
// instance; callers size-cast their operands in and the result back out.
package ram_pkg;

    localparam int RDW_WRITE_FIRST = 0;
    localparam int RDW_READ_FIRST  = 1;

    localparam int MAX_DATA_W = 256;
    localparam int MAX_NB     = 256;

    function automatic int num_lanes(input int data_w, input int byte_w);
        return data_w / byte_w;
    endfunction

    function automatic logic [MAX_DATA_W-1:0] merge_bytes(
        input logic [MAX_DATA_W-1:0] old_w,
        input logic [MAX_DATA_W-1:0] new_w,
        input logic [MAX_NB-1:0]     we,
        input int                    byte_w
    );
        logic [MAX_DATA_W-1:0] lane_ones;
        logic [MAX_DATA_W-1:0] mask;
        lane_ones = {MAX_DATA_W{1'b1}} >> (MAX_DATA_W - byte_w);
        mask      = '0;
        for (int l = 0; l < MAX_NB; l++) begin
            if ((we & (MAX_NB'(1) << l)) != '0) begin
                mask = mask | (lane_ones << (l * byte_w));
            end
        end
        return (old_w & ~mask) | (new_w & mask);
    endfunction

endpackage

// File: rtl/true_dual_port_ram_v2_out_pipe.sv
// ram_out_pipe: per-port read result pipeline.
//   clk, rst : clock and synchronous active-high reset
//   en_i     : access accepted this cycle
//   coll_i   : cross-port same-address collision this cycle
//   rd_i     : read word resolved for this access
//   q_o, valid_o, coll_o : results, 1 cycle late (OUT_REG = 0) or 2 (OUT_REG = 1)
// The first stage holds q when no access is accepted so the port output
// keeps its last value; reset clears every stage so in-flight results vanish.
module ram_out_pipe #(
    parameter int DATA_W  = 16,
    parameter int OUT_REG = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic              coll_i,
    input  logic [DATA_W-1:0] rd_i,
    output logic [DATA_W-1:0] q_o,
    output logic              valid_o,
    output logic              coll_o
);

    logic [DATA_W-1:0] q1_q, q1_d;
    logic              valid1_q, valid1_d;
    logic              coll1_q, coll1_d;

    always_comb begin
        q1_d     = en_i ? rd_i : q1_q;
        valid1_d = en_i;
        coll1_d  = coll_i;
    end

    // stage 1: array read result
    always_ff @(posedge clk) begin
        if (rst) begin
            q1_q     <= '0;
            valid1_q <= 1'b0;
            coll1_q  <= 1'b0;
        end else begin
            q1_q     <= q1_d;
            valid1_q <= valid1_d;
            coll1_q  <= coll1_d;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_reg
            logic [DATA_W-1:0] q2_q, q2_d;
            logic              valid2_q, valid2_d;
            logic              coll2_q, coll2_d;

            always_comb begin
                q2_d     = q1_q;
                valid2_d = valid1_q;
                coll2_d  = coll1_q;
            end

            // stage 2: optional output register
            always_ff @(posedge clk) begin
                if (rst) begin
                    q2_q     <= '0;
                    valid2_q <= 1'b0;
                    coll2_q  <= 1'b0;
                end else begin
                    q2_q     <= q2_d;
                    valid2_q <= valid2_d;
                    coll2_q  <= coll2_d;
                end
            end

            assign q_o     = q2_q;
            assign valid_o = valid2_q;
            assign coll_o  = coll2_q;
        end else begin : g_bypass
            assign q_o     = q1_q;
            assign valid_o = valid1_q;
            assign coll_o  = coll1_q;
        end
    endgenerate

endmodule

// File: rtl/true_dual_port_ram_v2.sv
// true_dual_port_ram_v2: two read/write ports on one clock over a shared array.
//   clk, rst                        : clock, synchronous active-high reset
//   en_x, we_x, addr_x, data_x      : port x enable, byte enables, address, write data
//   q_x, valid_x                    : port x read data and per-access valid pulse
//   collision                       : both ports hit the same address in the aligned access
// Read-during-write per port is set by RDW_MODE; OUT_REG adds a result stage.
// On a same-address write/write, B's lanes are applied first and A's on top,
// so A wins every lane both ports enable.
module true_dual_port_ram_v2
    import ram_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int BYTE_W   = 8,
    parameter int ADDR_W   = 6,
    parameter int RDW_MODE = 0,
    parameter int OUT_REG  = 0,
    localparam int NB      = num_lanes(DATA_W, BYTE_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_a,
    input  logic [NB-1:0]     we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] data_a,
    output logic [DATA_W-1:0] q_a,
    output logic              valid_a,
    input  logic              en_b,
    input  logic [NB-1:0]     we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] data_b,
    output logic [DATA_W-1:0] q_b,
    output logic              valid_b,
    output logic              collision
);

    localparam int DEPTH = 2 ** ADDR_W;

    generate
        if (DATA_W % BYTE_W != 0) begin : g_chk_lane
            $fatal(1, "DATA_W must be a multiple of BYTE_W");
        end
        if (ADDR_W < 1) begin : g_chk_addr
            $fatal(1, "ADDR_W must be at least 1");
        end
        if (DATA_W > MAX_DATA_W) begin : g_chk_width
            $fatal(1, "DATA_W exceeds the merge helper width");
        end
    endgenerate

    function automatic logic [DATA_W-1:0] merge_lanes(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] new_w,
        input logic [NB-1:0]     we
    );
        return DATA_W'(merge_bytes(MAX_DATA_W'(old_w), MAX_DATA_W'(new_w),
                                   MAX_NB'(we), BYTE_W));
    endfunction

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [DATA_W-1:0] old_a, old_b;
    logic [DATA_W-1:0] merged_a, merged_b, merged_both;
    logic [DATA_W-1:0] rd_a, rd_b;
    logic              wr_a, wr_b, coll;
    logic              coll_a, coll_b;

    always_comb begin
        old_a    = mem_q[addr_a];
        old_b    = mem_q[addr_b];
        wr_a     = en_a & (|we_a);
        wr_b     = en_b & (|we_b);
        coll     = en_a & en_b & (addr_a == addr_b);
        merged_a = merge_lanes(old_a, data_a, we_a);
        merged_b = merge_lanes(old_b, data_b, we_b);
        // only meaningful on a collision, where old_a == old_b
        merged_both = merge_lanes(merged_b, data_a, we_a);

        // a reading port always sees the pre-write word; only a writing
        // port in write-first mode sees the stored result
        if (coll) begin
            rd_a = (wr_a && RDW_MODE == RDW_WRITE_FIRST) ? merged_both : old_a;
            rd_b = (wr_b && RDW_MODE == RDW_WRITE_FIRST) ? merged_both : old_b;
        end else begin
            rd_a = (wr_a && RDW_MODE == RDW_WRITE_FIRST) ? merged_a : old_a;
            rd_b = (wr_b && RDW_MODE == RDW_WRITE_FIRST) ? merged_b : old_b;
        end
    end

    // storage update; contents survive reset, writes are suppressed during it
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (coll) begin
                if (wr_a || wr_b) begin
                    mem_q[addr_a] <= merged_both;
                end
            end else begin
                if (wr_a) begin
                    mem_q[addr_a] <= merged_a;
                end
                if (wr_b) begin
                    mem_q[addr_b] <= merged_b;
                end
            end
        end
    end

    ram_out_pipe #(
        .DATA_W (DATA_W),
        .OUT_REG(OUT_REG)
    ) u_pipe_a (
        .clk    (clk),
        .rst    (rst),
        .en_i   (en_a),
        .coll_i (coll),
        .rd_i   (rd_a),
        .q_o    (q_a),
        .valid_o(valid_a),
        .coll_o (coll_a)
    );

    ram_out_pipe #(
        .DATA_W (DATA_W),
        .OUT_REG(OUT_REG)
    ) u_pipe_b (
        .clk    (clk),
        .rst    (rst),
        .en_i   (en_b),
        .coll_i (coll),
        .rd_i   (rd_b),
        .q_o    (q_b),
        .valid_o(valid_b),
        .coll_o (coll_b)
    );

    // both pipes carry the same flag; combining them keeps both in use
    assign collision = coll_a & coll_b;

endmodule

// File: tb/tb_true_dual_port_ram_v2.sv
// Testbench for true_dual_port_ram_v2. Two instances share one stimulus
// stream: dut0 is write-first with latency 1, dut1 is read-first with
// latency 2. A word-level memory model predicts every output each cycle.
module tb_true_dual_port_ram_v2;

    localparam int DATA_W = 16;
    localparam int BYTE_W = 8;
    localparam int ADDR_W = 6;
    localparam int NB     = DATA_W / BYTE_W;
    localparam int DEPTH  = 2 ** ADDR_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              en_a, en_b;
    logic [NB-1:0]     we_a, we_b;
    logic [ADDR_W-1:0] addr_a, addr_b;
    logic [DATA_W-1:0] data_a, data_b;

    logic [DATA_W-1:0] q_a0, q_b0, q_a1, q_b1;
    logic              valid_a0, valid_b0, valid_a1, valid_b1;
    logic              coll0, coll1;

    true_dual_port_ram_v2 #(
        .DATA_W(DATA_W), .BYTE_W(BYTE_W), .ADDR_W(ADDR_W),
        .RDW_MODE(0), .OUT_REG(0)
    ) dut0 (
        .clk(clk), .rst(rst),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .data_a(data_a),
        .q_a(q_a0), .valid_a(valid_a0),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .data_b(data_b),
        .q_b(q_b0), .valid_b(valid_b0),
        .collision(coll0)
    );

    true_dual_port_ram_v2 #(
        .DATA_W(DATA_W), .BYTE_W(BYTE_W), .ADDR_W(ADDR_W),
        .RDW_MODE(1), .OUT_REG(1)
    ) dut1 (
        .clk(clk), .rst(rst),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .data_a(data_a),
        .q_a(q_a1), .valid_a(valid_a1),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .data_b(data_b),
        .q_b(q_b1), .valid_b(valid_b1),
        .collision(coll1)
    );

    typedef struct packed {
        logic [DATA_W-1:0] qa;
        logic [DATA_W-1:0] qb;
        logic              va;
        logic              vb;
        logic              c;
    } out_t;

    int total = 0;
    int bad   = 0;

    logic [DATA_W-1:0] mem [DEPTH];
    out_t e0;   // dut0 expected outputs
    out_t s1;   // dut1 result one cycle from its outputs
    out_t e1;   // dut1 expected outputs

    task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                         input logic [DATA_W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Predict the effect of the inputs at the coming edge, step over it and
    // compare every output.
    task automatic cycle();
        logic [DATA_W-1:0] old_a, old_b;
        logic              wa, wb, c;
        if (rst) begin
            e0 = '0;
            s1 = '0;
            e1 = '0;
        end else begin
            old_a = mem[addr_a];
            old_b = mem[addr_b];
            wa    = en_a && (we_a != '0);
            wb    = en_b && (we_b != '0);
            c     = en_a && en_b && (addr_a == addr_b);
            // B's lanes then A's, so A owns lanes both ports write
            for (int i = 0; i < NB; i++) begin
                if (en_b && we_b[i]) mem[addr_b][i*BYTE_W +: BYTE_W] = data_b[i*BYTE_W +: BYTE_W];
            end
            for (int i = 0; i < NB; i++) begin
                if (en_a && we_a[i]) mem[addr_a][i*BYTE_W +: BYTE_W] = data_a[i*BYTE_W +: BYTE_W];
            end
            // write-first, latency 1
            e0.va = en_a;
            e0.vb = en_b;
            e0.c  = c;
            if (en_a) e0.qa = wa ? mem[addr_a] : old_a;
            if (en_b) e0.qb = wb ? mem[addr_b] : old_b;
            // read-first, latency 2
            e1 = s1;
            s1.va = en_a;
            s1.vb = en_b;
            s1.c  = c;
            if (en_a) s1.qa = old_a;
            if (en_b) s1.qb = old_b;
        end
        @(posedge clk);
        #1;
        check("q_a0", q_a0, e0.qa);
        check("q_b0", q_b0, e0.qb);
        check("valid_a0", {15'd0, valid_a0}, {15'd0, e0.va});
        check("valid_b0", {15'd0, valid_b0}, {15'd0, e0.vb});
        check("coll0", {15'd0, coll0}, {15'd0, e0.c});
        check("q_a1", q_a1, e1.qa);
        check("q_b1", q_b1, e1.qb);
        check("valid_a1", {15'd0, valid_a1}, {15'd0, e1.va});
        check("valid_b1", {15'd0, valid_b1}, {15'd0, e1.vb});
        check("coll1", {15'd0, coll1}, {15'd0, e1.c});
    endtask

    task automatic acc(input logic ea, input logic [NB-1:0] wa, input logic [ADDR_W-1:0] aa,
                       input logic [DATA_W-1:0] da,
                       input logic eb, input logic [NB-1:0] wb, input logic [ADDR_W-1:0] ab,
                       input logic [DATA_W-1:0] db);
        en_a   = ea;
        we_a   = wa;
        addr_a = aa;
        data_a = da;
        en_b   = eb;
        we_b   = wb;
        addr_b = ab;
        data_b = db;
        cycle();
    endtask

    task automatic idle();
        acc(1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
    endtask

    function automatic logic [DATA_W-1:0] init_word(input int a);
        case (a)
            2:       return 16'hCAFE;
            3:       return 16'h1234;
            5:       return 16'h5A5A;
            7:       return 16'h00FF;
            9:       return 16'h0000;
            default: return DATA_W'($urandom);
        endcase
    endfunction

    initial begin
        e0 = '0;
        s1 = '0;
        e1 = '0;
        rst = 1'b1;
        idle();
        idle();
        rst = 1'b0;

        // 64 back-to-back writes on A fill the whole array
        for (int a = 0; a < DEPTH; a++) begin
            acc(1'b1, 2'b11, ADDR_W'(a), init_word(a), 1'b0, '0, '0, '0);
        end
        idle();

        // reset with live accesses: nothing comes out, nothing is written
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            acc(1'b1, 2'b11, 6'd5, 16'hFFFF, 1'b1, 2'b11, 6'd5, 16'hEEEE);
            check("rst_q_a0", q_a0, 16'h0000);
            check("rst_valid_a1", {15'd0, valid_a1}, 16'h0000);
            check("rst_coll0", {15'd0, coll0}, 16'h0000);
        end
        rst = 1'b0;
        acc(1'b1, 2'b00, 6'd5, 16'h0000, 1'b0, '0, '0, '0);
        check("post_rst_read5", q_a0, 16'h5A5A);
        idle();

        // byte write, write-first
        acc(1'b1, 2'b01, 6'd3, 16'hABCD, 1'b0, '0, '0, '0);
        check("bytewr_q_a0", q_a0, 16'h12CD);
        check("bytewr_valid_a0", {15'd0, valid_a0}, 16'h0001);
        acc(1'b1, 2'b00, 6'd3, 16'h0000, 1'b0, '0, '0, '0);
        check("bytewr_reread", q_a0, 16'h12CD);
        idle();

        // read-first with output register
        acc(1'b1, 2'b11, 6'd7, 16'h5555, 1'b0, '0, '0, '0);
        idle();
        check("rf_q_a1_old", q_a1, 16'h00FF);
        acc(1'b1, 2'b00, 6'd7, 16'h0000, 1'b0, '0, '0, '0);
        idle();
        check("rf_q_a1_new", q_a1, 16'h5555);

        // write/write collision
        acc(1'b1, 2'b10, 6'd9, 16'h1111, 1'b1, 2'b11, 6'd9, 16'h2222);
        check("ww_coll0", {15'd0, coll0}, 16'h0001);
        check("ww_q_a0", q_a0, 16'h1122);
        check("ww_q_b0", q_b0, 16'h1122);
        idle();
        check("ww_coll1", {15'd0, coll1}, 16'h0001);
        check("ww_valid_b1", {15'd0, valid_b1}, 16'h0001);
        acc(1'b0, '0, '0, '0, 1'b1, 2'b00, 6'd9, 16'h0000);
        check("ww_stored", q_b0, 16'h1122);
        idle();

        // write/read collision
        acc(1'b1, 2'b11, 6'd2, 16'hBEEF, 1'b1, 2'b00, 6'd2, 16'h0000);
        check("wr_q_b0_old", q_b0, 16'hCAFE);
        check("wr_coll0", {15'd0, coll0}, 16'h0001);
        acc(1'b0, '0, '0, '0, 1'b1, 2'b00, 6'd2, 16'h0000);
        check("wr_q_b0_new", q_b0, 16'hBEEF);
        idle();
        idle();

        // reset one cycle after an accepted read drops it in the 2-stage pipe
        acc(1'b1, 2'b00, 6'd3, 16'h0000, 1'b0, '0, '0, '0);
        rst = 1'b1;
        idle();
        check("midrst_valid_a1", {15'd0, valid_a1}, 16'h0000);
        rst = 1'b0;
        idle();
        check("midrst_valid_a1_after", {15'd0, valid_a1}, 16'h0000);

        // 64 back-to-back reads on B
        for (int a = 0; a < DEPTH; a++) begin
            acc(1'b0, '0, '0, '0, 1'b1, 2'b00, ADDR_W'(a), 16'h0000);
            check("b2b_valid_b0", {15'd0, valid_b0}, 16'h0001);
        end
        idle();

        // random traffic on a narrow address range to provoke collisions
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 39) == 0);
            acc(1'($urandom), NB'($urandom), ADDR_W'($urandom_range(0, 7)), DATA_W'($urandom),
                1'($urandom), NB'($urandom), ADDR_W'($urandom_range(0, 7)), DATA_W'($urandom));
        end
        rst = 1'b0;
        idle();
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
